// File: rtl/control_unit_if.sv
// Bus between the control_unit sequencer and the datapath (PC, memory, ALU, accumulator).
// The master modport is the sequencer side; the slave modport is the datapath side.
interface control_unit_if;
    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;

    logic           run;
    logic [DW-1:0]  pc_value;
    logic [DW-1:0]  mem_rdata;
    logic [DW-1:0]  acc_value;
    logic [DW-1:0]  alu_result;
    logic           alu_zero;

    logic           pc_load;
    logic           pc_increment;
    logic [DW-1:0]  pc_target;
    logic [DW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_we;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_b;
    logic           acc_load;
    logic [DW-1:0]  acc_din;
    logic           z_flag;
    logic           halted;

    modport master (
        input  run, pc_value, mem_rdata, acc_value, alu_result, alu_zero,
        output pc_load, pc_increment, pc_target, mem_addr, mem_wdata, mem_we,
               alu_op, alu_b, acc_load, acc_din, z_flag, halted
    );

    modport slave (
        output run, pc_value, mem_rdata, acc_value, alu_result, alu_zero,
        input  pc_load, pc_increment, pc_target, mem_addr, mem_wdata, mem_we,
               alu_op, alu_b, acc_load, acc_din, z_flag, halted
    );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Strobes are Mealy outputs of state, ir and mem_rdata; ir, opr, z_flag and halted are registered.
module control_unit (
    input  logic         clk,
    input  logic         reset,
    control_unit_if.master bus
);
    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;
    localparam int unsigned SW  = 3;

    localparam logic [SW-1:0] S_FETCH   = 3'd0;
    localparam logic [SW-1:0] S_DECODE  = 3'd1;
    localparam logic [SW-1:0] S_OPERAND = 3'd2;
    localparam logic [SW-1:0] S_MEMRD   = 3'd3;
    localparam logic [SW-1:0] S_HALT    = 3'd4;

    localparam logic [OPW-1:0] C_NOP  = 4'h0;
    localparam logic [OPW-1:0] C_LDI  = 4'h1;
    localparam logic [OPW-1:0] C_LDA  = 4'h2;
    localparam logic [OPW-1:0] C_STA  = 4'h3;
    localparam logic [OPW-1:0] C_ALUI = 4'h4;
    localparam logic [OPW-1:0] C_ALUM = 4'h5;
    localparam logic [OPW-1:0] C_JMP  = 4'h6;
    localparam logic [OPW-1:0] C_JZ   = 4'h7;
    localparam logic [OPW-1:0] C_HLT  = 4'hF;

    logic [SW-1:0]  state_q, state_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [DW-1:0]  opr_q, opr_d;
    logic           z_q, z_d;
    logic           halted_q, halted_d;

    logic [OPW-1:0] dec_cls;
    logic [OPW-1:0] ir_cls;

    logic           pc_load_c;
    logic           pc_increment_c;
    logic [DW-1:0]  pc_target_c;
    logic [DW-1:0]  mem_addr_c;
    logic [DW-1:0]  mem_wdata_c;
    logic           mem_we_c;
    logic [OPW-1:0] alu_op_c;
    logic [DW-1:0]  alu_b_c;
    logic           acc_load_c;
    logic [DW-1:0]  acc_din_c;

    assign dec_cls = bus.mem_rdata[7:4];
    assign ir_cls  = ir_q[7:4];

    // Next-state and Mealy strobe logic
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        opr_d          = opr_q;
        z_d            = z_q;
        pc_load_c      = 1'b0;
        pc_increment_c = 1'b0;
        pc_target_c    = '0;
        mem_addr_c     = '0;
        mem_wdata_c    = '0;
        mem_we_c       = 1'b0;
        alu_op_c       = '0;
        alu_b_c        = '0;
        acc_load_c     = 1'b0;
        acc_din_c      = '0;

        case (state_q)
            S_FETCH: begin
                if (bus.run) begin
                    mem_addr_c     = bus.pc_value;
                    pc_increment_c = 1'b1;
                    state_d        = S_DECODE;
                end
            end

            S_DECODE: begin
                ir_d = bus.mem_rdata;
                if (dec_cls == C_HLT) begin
                    state_d = S_HALT;
                end else if (dec_cls == C_NOP || dec_cls[3]) begin
                    // Classes 0x8..0xE are undefined and behave as NOP
                    state_d = S_FETCH;
                end else begin
                    mem_addr_c     = bus.pc_value;
                    pc_increment_c = 1'b1;
                    state_d        = S_OPERAND;
                end
            end

            S_OPERAND: begin
                state_d = S_FETCH;
                case (ir_cls)
                    C_LDI: begin
                        acc_load_c = 1'b1;
                        acc_din_c  = bus.mem_rdata;
                        z_d        = (bus.mem_rdata == '0);
                    end
                    C_ALUI: begin
                        alu_op_c   = ir_q[3:0];
                        alu_b_c    = bus.mem_rdata;
                        acc_load_c = 1'b1;
                        acc_din_c  = bus.alu_result;
                        z_d        = bus.alu_zero;
                    end
                    C_JMP: begin
                        pc_load_c   = 1'b1;
                        pc_target_c = bus.mem_rdata;
                    end
                    C_JZ: begin
                        pc_load_c   = z_q;
                        pc_target_c = bus.mem_rdata;
                    end
                    C_STA: begin
                        mem_addr_c  = bus.mem_rdata;
                        mem_wdata_c = bus.acc_value;
                        mem_we_c    = 1'b1;
                    end
                    C_LDA, C_ALUM: begin
                        mem_addr_c = bus.mem_rdata;
                        opr_d      = bus.mem_rdata;
                        state_d    = S_MEMRD;
                    end
                    default: ;
                endcase
            end

            S_MEMRD: begin
                // Keep the data address on the bus while the read completes
                mem_addr_c = opr_q;
                state_d    = S_FETCH;
                if (ir_cls == C_LDA) begin
                    acc_load_c = 1'b1;
                    acc_din_c  = bus.mem_rdata;
                    z_d        = (bus.mem_rdata == '0);
                end else if (ir_cls == C_ALUM) begin
                    alu_op_c   = ir_q[3:0];
                    alu_b_c    = bus.mem_rdata;
                    acc_load_c = 1'b1;
                    acc_din_c  = bus.alu_result;
                    z_d        = bus.alu_zero;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset aborts any instruction in flight: no strobe may escape this cycle
        if (!reset) begin
            pc_load_c      = 1'b0;
            pc_increment_c = 1'b0;
            pc_target_c    = '0;
            mem_addr_c     = '0;
            mem_wdata_c    = '0;
            mem_we_c       = 1'b0;
            alu_op_c       = '0;
            alu_b_c        = '0;
            acc_load_c     = 1'b0;
            acc_din_c      = '0;
        end

        halted_d = (state_d == S_HALT);
    end

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            ir_q     <= '0;
            opr_q    <= '0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            opr_q    <= opr_d;
            z_q      <= z_d;
            halted_q <= halted_d;
        end
    end

    assign bus.pc_load      = pc_load_c;
    assign bus.pc_increment = pc_increment_c;
    assign bus.pc_target    = pc_target_c;
    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_wdata    = mem_wdata_c;
    assign bus.mem_we       = mem_we_c;
    assign bus.alu_op       = alu_op_c;
    assign bus.alu_b        = alu_b_c;
    assign bus.acc_load     = acc_load_c;
    assign bus.acc_din      = acc_din_c;
    assign bus.z_flag       = z_q;
    assign bus.halted       = halted_q;
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: TB-side PC, memory, ALU and accumulator,
// directed scenarios plus random programs checked against an instruction-level model.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       load_req;
    logic [7:0] img     [256];
    logic [7:0] mem     [256];
    logic [7:0] mdl_mem [256];
    logic [7:0] pc_q;
    logic [7:0] acc_q;
    logic [7:0] rdata_q;
    logic [7:0] exp_pc, exp_acc;
    logic       exp_z;
    int         exp_cyc;
    bit         both_seen;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    control_unit_if bus ();
    assign bus.run        = run;
    assign bus.pc_value   = pc_q;
    assign bus.mem_rdata  = rdata_q;
    assign bus.acc_value  = acc_q;
    assign bus.alu_result = alu_f(bus.alu_op, acc_q, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == 8'h00);

    control_unit dut (.clk(clk), .reset(reset), .bus(bus));

    // Datapath stand-ins: registered memory read, PC and accumulator
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        rdata_q <= mem[bus.mem_addr];
        if (!reset)                pc_q <= 8'h00;
        else if (bus.pc_load)      pc_q <= bus.pc_target;
        else if (bus.pc_increment) pc_q <= pc_q + 8'd1;
        if (!reset)                acc_q <= 8'h00;
        else if (bus.acc_load)     acc_q <= bus.acc_din;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    endtask

    // Load img, hold reset, release so that the next edge ends cycle 1 (FETCH)
    task automatic start;
        reset = 1'b0;
        run = 1'b1;
        load_req = 1'b1;
        tick;
        load_req = 1'b0;
        tick;
        reset = 1'b1;
    endtask

    task automatic run_dut(output int cyc, output bit to);
        cyc = 0;
        to = 1'b0;
        both_seen = 1'b0;
        while (bus.halted !== 1'b1) begin
            if (bus.pc_load && bus.pc_increment) both_seen = 1'b1;
            tick;
            cyc++;
            if (cyc >= 2000) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    // Instruction-level interpreter of the ISA with its cycle costs
    task automatic run_model;
        logic [7:0] p, a, o, op;
        logic [3:0] cls;
        logic       zz, done;
        for (int i = 0; i < 256; i++) mdl_mem[i] = img[i];
        p = 8'h00; a = 8'h00; zz = 1'b0; done = 1'b0;
        exp_cyc = 0;
        for (int s = 0; s < 300 && !done; s++) begin
            op = mdl_mem[p];
            p = p + 8'd1;
            cls = op[7:4];
            if (cls == 4'hF) begin
                exp_cyc += 2;
                done = 1'b1;
            end else if (cls == 4'h0 || cls >= 4'h8) begin
                exp_cyc += 2;
            end else begin
                o = mdl_mem[p];
                p = p + 8'd1;
                case (cls)
                    4'h1: begin a = o; zz = (a == 8'h00); exp_cyc += 3; end
                    4'h2: begin a = mdl_mem[o]; zz = (a == 8'h00); exp_cyc += 4; end
                    4'h3: begin mdl_mem[o] = a; exp_cyc += 3; end
                    4'h4: begin a = alu_f(op[3:0], a, o); zz = (a == 8'h00); exp_cyc += 3; end
                    4'h5: begin a = alu_f(op[3:0], a, mdl_mem[o]); zz = (a == 8'h00); exp_cyc += 4; end
                    4'h6: begin p = o; exp_cyc += 3; end
                    default: begin if (zz) p = o; exp_cyc += 3; end
                endcase
            end
        end
        exp_pc = p;
        exp_acc = a;
        exp_z = zz;
    endtask

    task automatic test_reset;
        clear_img;
        reset = 1'b0;
        run = 1'b1;
        load_req = 1'b1;
        tick;
        load_req = 1'b0;
        tick;
        checks++;
        if ({bus.pc_load, bus.pc_increment, bus.mem_we, bus.acc_load} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0000", {bus.pc_load, bus.pc_increment, bus.mem_we, bus.acc_load});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.alu_b, bus.pc_target, bus.acc_din, bus.alu_op} !== 44'h0) begin
            errors++;
            $display("FAIL reset_buses got %h exp 0", {bus.mem_addr, bus.mem_wdata, bus.alu_b, bus.pc_target, bus.acc_din, bus.alu_op});
        end
        checks++;
        if ({bus.halted, bus.z_flag} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got halted=%b z=%b exp 0 0", bus.halted, bus.z_flag);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_addr !== 8'h00 || bus.pc_increment !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_fetch got addr=%h inc=%b exp 00 1", bus.mem_addr, bus.pc_increment);
        end
    endtask

    task automatic test_program;
        bit we_bad = 1'b0, halt_bad = 1'b0;
        logic [7:0] acc3 = 8'h00, acc6 = 8'h00;
        clear_img;
        img[0] = 8'h10; img[1] = 8'h05; img[2] = 8'h41; img[3] = 8'h03;
        img[4] = 8'h30; img[5] = 8'h80; img[6] = 8'hF0;
        start;
        for (int k = 1; k <= 15; k++) begin
            if (k == 9) begin
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h80 || bus.mem_wdata !== 8'h08) we_bad = 1'b1;
            end else if (bus.mem_we !== 1'b0) begin
                we_bad = 1'b1;
            end
            tick;
            if (k == 3) acc3 = acc_q;
            if (k == 6) acc6 = acc_q;
            if (k == 10 && bus.halted !== 1'b0) halt_bad = 1'b1;
            if (k >= 11 && bus.halted !== 1'b1) halt_bad = 1'b1;
        end
        checks++;
        if (acc3 !== 8'h05) begin errors++; $display("FAIL prog_ldi_acc got %h exp 05", acc3); end
        checks++;
        if (acc6 !== 8'h08) begin errors++; $display("FAIL prog_alui_acc got %h exp 08", acc6); end
        checks++;
        if (we_bad) begin errors++; $display("FAIL prog_sta_write got bad mem_we timing exp one pulse in cycle 9"); end
        checks++;
        if (mem[8'h80] !== 8'h08) begin errors++; $display("FAIL prog_mem80 got %h exp 08", mem[8'h80]); end
        checks++;
        if (halt_bad) begin errors++; $display("FAIL prog_halted got wrong timing exp high from cycle 11"); end
    endtask

    task automatic test_jz(input logic [7:0] val);
        int cyc;
        bit to;
        logic take = (val == 8'h00);
        clear_img;
        img[0] = 8'h10; img[1] = val; img[2] = 8'h70; img[3] = 8'h20;
        img[4] = 8'h10; img[5] = 8'h77; img[6] = 8'hF0;
        img[8'h20] = 8'h10; img[8'h21] = 8'h33; img[8'h22] = 8'hF0;
        start;
        tick; tick; tick;
        checks++;
        if (bus.z_flag !== take) begin errors++; $display("FAIL jz_zflag got %b exp %b", bus.z_flag, take); end
        tick; tick;
        checks++;
        if (bus.pc_load !== take || (take && bus.pc_target !== 8'h20)) begin
            errors++;
            $display("FAIL jz_pc_load got load=%b tgt=%h exp %b 20", bus.pc_load, bus.pc_target, take);
        end
        run_dut(cyc, to);
        checks++;
        if (to || acc_q !== (take ? 8'h33 : 8'h77)) begin
            errors++;
            $display("FAIL jz_path got acc=%h timeout=%b exp %h", acc_q, to, take ? 8'h33 : 8'h77);
        end
    endtask

    task automatic test_lda_alum;
        logic [7:0] acc3;
        clear_img;
        img[0] = 8'h20; img[1] = 8'h40; img[2] = 8'h55; img[3] = 8'h40; img[4] = 8'hF0;
        img[8'h40] = 8'hA5;
        start;
        tick; tick; tick;
        acc3 = acc_q;
        tick;
        checks++;
        if (acc3 !== 8'h00 || acc_q !== 8'hA5 || bus.z_flag !== 1'b0) begin
            errors++;
            $display("FAIL lda_4cyc got acc3=%h acc4=%h z=%b exp 00 a5 0", acc3, acc_q, bus.z_flag);
        end
        tick; tick; tick;
        checks++;
        if (bus.alu_b !== 8'hA5 || bus.alu_op !== 4'h5 || bus.acc_load !== 1'b1 || bus.acc_din !== 8'h00) begin
            errors++;
            $display("FAIL alum_memrd got b=%h op=%h ld=%b din=%h exp a5 5 1 00", bus.alu_b, bus.alu_op, bus.acc_load, bus.acc_din);
        end
        tick;
        checks++;
        if (bus.z_flag !== 1'b1 || acc_q !== 8'h00) begin
            errors++;
            $display("FAIL alum_z got z=%b acc=%h exp 1 00", bus.z_flag, acc_q);
        end
    endtask

    task automatic test_run_drop;
        int cyc;
        bit to, idle_bad = 1'b0;
        clear_img;
        img[0] = 8'h20; img[1] = 8'h40; img[2] = 8'h10; img[3] = 8'h11; img[4] = 8'hF0;
        img[8'h40] = 8'hA5;
        start;
        tick;
        run = 1'b0;
        tick; tick; tick;
        checks++;
        if (acc_q !== 8'hA5) begin errors++; $display("FAIL rundrop_lda got %h exp a5", acc_q); end
        for (int k = 0; k < 3; k++) begin
            if ({bus.pc_load, bus.pc_increment, bus.mem_we, bus.acc_load} !== 4'b0000) idle_bad = 1'b1;
            tick;
        end
        checks++;
        if (idle_bad || pc_q !== 8'h02) begin
            errors++;
            $display("FAIL rundrop_idle got strobes_seen=%b pc=%h exp 0 02", idle_bad, pc_q);
        end
        run = 1'b1;
        #1;
        checks++;
        if (bus.mem_addr !== 8'h02 || bus.pc_increment !== 1'b1) begin
            errors++;
            $display("FAIL rundrop_resume got addr=%h inc=%b exp 02 1", bus.mem_addr, bus.pc_increment);
        end
        run_dut(cyc, to);
        checks++;
        if (to || acc_q !== 8'h11) begin errors++; $display("FAIL rundrop_final got acc=%h to=%b exp 11", acc_q, to); end
    endtask

    task automatic test_reset_mid_sta;
        logic pre_we;
        clear_img;
        img[0] = 8'h10; img[1] = 8'h5A; img[2] = 8'h30; img[3] = 8'h90; img[4] = 8'hF0;
        img[8'h90] = 8'h00;
        start;
        for (int k = 0; k < 5; k++) tick;
        pre_we = bus.mem_we;
        reset = 1'b0;
        #1;
        checks++;
        if (pre_we !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL sta_reset_strobe got pre=%b we=%b addr=%h exp 1 0 00", pre_we, bus.mem_we, bus.mem_addr);
        end
        tick;
        checks++;
        if (mem[8'h90] !== 8'h00) begin errors++; $display("FAIL sta_reset_mem got %h exp 00", mem[8'h90]); end
        reset = 1'b1;
    endtask

    task automatic test_undefined;
        logic [3:0] s2;
        clear_img;
        img[0] = 8'h9C; img[1] = 8'hF0;
        start;
        tick;
        s2 = {bus.pc_load, bus.pc_increment, bus.mem_we, bus.acc_load};
        tick;
        checks++;
        if (s2 !== 4'b0000 || bus.mem_addr !== 8'h01 || bus.pc_increment !== 1'b1) begin
            errors++;
            $display("FAIL undef_nop got decode_strobes=%b addr=%h inc=%b exp 0000 01 1", s2, bus.mem_addr, bus.pc_increment);
        end
        tick; tick;
        checks++;
        if (bus.halted !== 1'b1 || acc_q !== 8'h00) begin
            errors++;
            $display("FAIL undef_halt got halted=%b acc=%h exp 1 00", bus.halted, acc_q);
        end
    endtask

    task automatic test_jmp_wrap;
        int cyc;
        bit to;
        clear_img;
        img[0] = 8'h60; img[1] = 8'hFF; img[8'hFF] = 8'h60;
        img[8'h60] = 8'h10; img[8'h61] = 8'h3C; img[8'h62] = 8'hF0;
        start;
        run_dut(cyc, to);
        checks++;
        if (to || cyc != 11 || acc_q !== 8'h3C || pc_q !== 8'h63) begin
            errors++;
            $display("FAIL jmp_wrap got cyc=%0d acc=%h pc=%h exp 11 3c 63", cyc, acc_q, pc_q);
        end
    endtask

    task automatic test_random;
        logic [3:0] cls [10];
        logic [7:0] at [11];
        logic [3:0] c;
        int pos, cyc, diffs;
        bit to;
        for (int r = 0; r < 12; r++) begin
            clear_img;
            pos = 0;
            for (int i = 0; i < 10; i++) begin
                c = 4'($urandom_range(0, 14));
                cls[i] = c;
                at[i] = 8'(pos);
                pos += (c >= 4'h1 && c <= 4'h7) ? 2 : 1;
            end
            at[10] = 8'(pos);
            img[at[10]] = 8'hF0;
            for (int i = 0; i < 10; i++) begin
                img[at[i]] = {cls[i], 4'($urandom_range(0, 15))};
                case (cls[i])
                    4'h1, 4'h4:       img[at[i] + 8'd1] = 8'($urandom);
                    4'h2, 4'h3, 4'h5: img[at[i] + 8'd1] = 8'h80 + 8'($urandom_range(0, 31));
                    4'h6, 4'h7:       img[at[i] + 8'd1] = at[$urandom_range(i + 1, 10)];
                    default: ;
                endcase
            end
            run_model;
            start;
            run_dut(cyc, to);
            diffs = 0;
            for (int j = 8'h80; j < 8'hA0; j++) if (mem[j] !== mdl_mem[j]) diffs++;
            checks++;
            if (to || cyc != exp_cyc) begin
                errors++;
                $display("FAIL rand%0d_cycles got %0d to=%b exp %0d", r, cyc, to, exp_cyc);
            end
            checks++;
            if (acc_q !== exp_acc || bus.z_flag !== exp_z || pc_q !== exp_pc) begin
                errors++;
                $display("FAIL rand%0d_state got acc=%h z=%b pc=%h exp %h %b %h", r, acc_q, bus.z_flag, pc_q, exp_acc, exp_z, exp_pc);
            end
            checks++;
            if (diffs != 0 || both_seen) begin
                errors++;
                $display("FAIL rand%0d_mem got %0d diffs pcboth=%b exp 0 0", r, diffs, both_seen);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        run = 1'b0;
        load_req = 1'b0;
        test_reset;
        test_program;
        test_jz(8'h00);
        test_jz(8'h01);
        test_lda_alum;
        test_run_drop;
        test_reset_mid_sta;
        test_undefined;
        test_jmp_wrap;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
